// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the 9-bit-instruction CPU control path.
package cpu_ctrl_pkg;
  localparam int INSTR_W  = 9;
  localparam int DEF_PC_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    DONE,
    ERROR
  } seq_state_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts MEM-state cycles spent waiting for a data-memory ack; flags the limit cycle.
module mem_timeout_ctr #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr,
  input  logic en,
  output logic limit
);
  logic [CW-1:0] cnt;

  assign limit = (cnt == CW'(MEM_TIMEOUT - 1));

  // Saturates at the limit so a late ack can never see a wrapped count.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)             cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !limit)   cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/exec/mem/retire sequencer: owns PC and IR, qualifies decoder strobes.
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int START_ADDR  = 0,
  parameter int END_ADDR    = 1023,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               RegWriteDec,
  input  logic               MemWriteDec,
  input  logic               LoadDec,
  input  logic               BranchDec,
  input  logic               Zero,
  input  logic [PC_W-1:0]    BranchTarget,
  input  logic               MemAck,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] Ir,
  output logic               RegWriteEn,
  output logic               MemWriteEn,
  output logic               MemReadEn,
  output logic               Busy,
  output logic               Done,
  output logic               Error
);
  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               tmo_limit;
  logic               is_mem_op;
  seq_state_t         retire_st;

  mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .gclk   (Clk),
    .grst_n (Reset_n),
    .clr    (state_q != MEM),
    .en     ((state_q == MEM) && !MemAck),
    .limit  (tmo_limit)
  );

  assign is_mem_op = LoadDec | MemWriteDec;
  // The retiring PC decides end-of-program, regardless of where a branch goes.
  assign retire_st = (pc_q == PC_W'(END_ADDR)) ? DONE : FETCH;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    RegWriteEn = 1'b0;
    MemReadEn  = 1'b0;
    MemWriteEn = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (Start) begin
          pc_d    = PC_W'(START_ADDR);
          state_d = FETCH;
        end
      end
      FETCH: begin
        ir_d    = Instr;
        state_d = EXEC;
      end
      EXEC: begin
        if (is_mem_op) begin
          state_d = MEM;
        end else begin
          RegWriteEn = RegWriteDec;
          pc_d       = (BranchDec && Zero) ? BranchTarget : pc_q + PC_W'(1);
          state_d    = retire_st;
        end
      end
      MEM: begin
        MemReadEn  = LoadDec;
        MemWriteEn = MemWriteDec;
        // Ack beats the timeout when both land in the same cycle.
        if (MemAck) begin
          RegWriteEn = LoadDec;
          pc_d       = pc_q + PC_W'(1);
          state_d    = retire_st;
        end else if (tmo_limit) begin
          state_d = ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PC    = pc_q;
  assign Ir    = ir_q;
  assign Busy  = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEM);
  assign Done  = (state_q == DONE);
  assign Error = (state_q == ERROR);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: START_ADDR=1021, END_ADDR=1023, MEM_TIMEOUT=16.
module tb_instr_sequencer;
  logic       Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0;
  logic [8:0] Instr = '0;
  logic       RegWriteDec = 1'b0, MemWriteDec = 1'b0, LoadDec = 1'b0;
  logic       BranchDec = 1'b0, Zero = 1'b0, MemAck = 1'b0;
  logic [9:0] BranchTarget = '0;
  logic [9:0] PC;
  logic [8:0] Ir;
  logic       RegWriteEn, MemWriteEn, MemReadEn, Busy, Done, Error;

  int n_cmp = 0, n_err = 0;

  instr_sequencer #(
    .PC_W(10), .START_ADDR(1021), .END_ADDR(1023), .MEM_TIMEOUT(16)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instr(Instr),
    .RegWriteDec(RegWriteDec), .MemWriteDec(MemWriteDec), .LoadDec(LoadDec),
    .BranchDec(BranchDec), .Zero(Zero), .BranchTarget(BranchTarget),
    .MemAck(MemAck), .PC(PC), .Ir(Ir), .RegWriteEn(RegWriteEn),
    .MemWriteEn(MemWriteEn), .MemReadEn(MemReadEn), .Busy(Busy),
    .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic dec(input logic rw, input logic ld, input logic mw,
                     input logic br, input logic z, input logic [9:0] tgt);
    RegWriteDec = rw; LoadDec = ld; MemWriteDec = mw;
    BranchDec = br; Zero = z; BranchTarget = tgt;
    #1;
  endtask

  task automatic fetch(input string tg, input logic [9:0] epc, input logic [8:0] ins);
    chk({tg, ".f.busy"}, 32'(Busy), 32'd1);
    chk({tg, ".f.pc"}, 32'(PC), 32'(epc));
    chk({tg, ".f.rwen"}, 32'(RegWriteEn), 32'd0);
    Instr = ins;
    tick();
  endtask

  task automatic exec_alu(input string tg, input logic [8:0] ins, input logic rw,
                          input logic br, input logic z, input logic [9:0] tgt);
    dec(rw, 1'b0, 1'b0, br, z, tgt);
    chk({tg, ".x.ir"}, 32'(Ir), 32'(ins));
    chk({tg, ".x.rwen"}, 32'(RegWriteEn), 32'(rw));
    chk({tg, ".x.mren"}, 32'(MemReadEn), 32'd0);
    tick();
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.pc", 32'(PC), 32'd0);
    chk("rst.ir", 32'(Ir), 32'd0);
    chk("rst.busy", 32'(Busy), 32'd0);
    chk("rst.done", 32'(Done), 32'd0);
    chk("rst.err", 32'(Error), 32'd0);
    chk("rst.en", 32'({RegWriteEn, MemReadEn, MemWriteEn}), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    chk("idle.busy", 32'(Busy), 32'd0);

    // Three register-writing ALU ops 1021..1023; retiring END_ADDR wraps PC to 0.
    RegWriteDec = 1'b1;
    do_start();
    fetch("t1a", 10'd1021, 9'h101);
    exec_alu("t1a", 9'h101, 1'b1, 1'b0, 1'b0, 10'd0);
    fetch("t1b", 10'd1022, 9'h102);
    exec_alu("t1b", 9'h102, 1'b1, 1'b0, 1'b0, 10'd0);
    fetch("t1c", 10'd1023, 9'h103);
    exec_alu("t1c", 9'h103, 1'b1, 1'b0, 1'b0, 10'd0);
    chk("t1.done", 32'(Done), 32'd1);
    chk("t1.busy", 32'(Busy), 32'd0);
    chk("t1.pcwrap", 32'(PC), 32'd0);
    chk("t1.rwen_idle", 32'(RegWriteEn), 32'd0);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    chk("t1.ack_ignored", 32'({Done, PC}), 32'({1'b1, 10'd0}));

    // Branches: taken to 5, not-taken at 5, taken to 40, taken to 3.
    do_start();
    chk("t2.done_clr", 32'(Done), 32'd0);
    fetch("t2a", 10'd1021, 9'h1A0);
    exec_alu("t2a", 9'h1A0, 1'b0, 1'b1, 1'b1, 10'd5);
    fetch("t2b", 10'd5, 9'h1A1);
    exec_alu("t2b", 9'h1A1, 1'b0, 1'b1, 1'b0, 10'd40);
    fetch("t2c", 10'd6, 9'h1A2);
    exec_alu("t2c", 9'h1A2, 1'b0, 1'b1, 1'b1, 10'd40);
    fetch("t2d", 10'd40, 9'h1A3);
    exec_alu("t2d", 9'h1A3, 1'b0, 1'b1, 1'b1, 10'd3);

    // Load at 3, ack in the 4th MEM cycle.
    fetch("t3", 10'd3, 9'h0C3);
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    chk("t3.x.rwen", 32'(RegWriteEn), 32'd0);
    chk("t3.x.mren", 32'(MemReadEn), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t3.m.mren", 32'(MemReadEn), 32'd1);
      chk("t3.m.rwen", 32'(RegWriteEn), 32'd0);
      chk("t3.m.mwen", 32'(MemWriteEn), 32'd0);
      chk("t3.m.pc", 32'(PC), 32'd3);
      tick();
    end
    MemAck = 1'b1;
    #1;
    chk("t3.ack.mren", 32'(MemReadEn), 32'd1);
    chk("t3.ack.rwen", 32'(RegWriteEn), 32'd1);
    tick();
    MemAck = 1'b0;
    dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    chk("t3.after.mren", 32'(MemReadEn), 32'd0);

    // Store at 4, no ack: ERROR after 16 MEM cycles.
    fetch("t4", 10'd4, 9'h0E4);
    dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("t4.m.mwen", 32'(MemWriteEn), 32'd1);
      chk("t4.m.err", 32'(Error), 32'd0);
      tick();
    end
    chk("t4.err", 32'(Error), 32'd1);
    chk("t4.mwen", 32'(MemWriteEn), 32'd0);
    chk("t4.pc", 32'(PC), 32'd4);
    chk("t4.busy", 32'(Busy), 32'd0);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    chk("t4.sticky", 32'({Error, PC}), 32'({1'b1, 10'd4}));
    dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    do_start();
    chk("t4.err_clr", 32'(Error), 32'd0);

    // Store at 10, ack on the 16th MEM cycle; Start pulsed while busy.
    fetch("t5a", 10'd1021, 9'h1A4);
    exec_alu("t5a", 9'h1A4, 1'b0, 1'b1, 1'b1, 10'd10);
    fetch("t5", 10'd10, 9'h0EA);
    dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    tick();
    for (int i = 0; i < 15; i++) begin
      Start = (i == 5);
      #1;
      chk("t5.m.mwen", 32'(MemWriteEn), 32'd1);
      tick();
    end
    Start = 1'b0;
    MemAck = 1'b1;
    #1;
    chk("t5.ack.err", 32'(Error), 32'd0);
    chk("t5.ack.mwen", 32'(MemWriteEn), 32'd1);
    chk("t5.ack.rwen", 32'(RegWriteEn), 32'd0);
    tick();
    MemAck = 1'b0;
    dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    chk("t5.err", 32'(Error), 32'd0);
    fetch("t5b", 10'd11, 9'h1A5);
    exec_alu("t5b", 9'h1A5, 1'b0, 1'b1, 1'b1, 10'd1023);
    // Taken branch at END_ADDR still ends the program.
    fetch("t5c", 10'd1023, 9'h1A6);
    exec_alu("t5c", 9'h1A6, 1'b0, 1'b1, 1'b1, 10'd50);
    chk("t5.done", 32'(Done), 32'd1);
    chk("t5.pc", 32'(PC), 32'd50);

    // Reset dropped mid-MEM aborts at once.
    do_start();
    fetch("t6a", 10'd1021, 9'h1A7);
    exec_alu("t6a", 9'h1A7, 1'b0, 1'b1, 1'b1, 10'd20);
    fetch("t6", 10'd20, 9'h0C4);
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    tick();
    chk("t6.m.mren", 32'(MemReadEn), 32'd1);
    MemAck = 1'b1;
    #1;
    Reset_n = 1'b0;
    #1;
    chk("t6.rst.en", 32'({RegWriteEn, MemReadEn, MemWriteEn}), 32'd0);
    chk("t6.rst.busy", 32'(Busy), 32'd0);
    chk("t6.rst.pc", 32'(PC), 32'd0);
    chk("t6.rst.ir", 32'(Ir), 32'd0);
    MemAck = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    chk("t6.idle", 32'({Busy, Done, Error}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control FSM for the 9-bit-instruction CPU. It owns the program counter and times instruction fetch, execute, data-memory access and retirement. It qualifies the decoder's raw RegWrite/MemWrite/Load/branch strobes into single-cycle enables, and waits on a variable-latency data-memory ack with a timeout. It sits between instruction memory, the decoder/ALU/register file and data memory.

Parameters:
PC_W, 10, program counter width.
START_ADDR, 0, PC value loaded on Start.
END_ADDR, 1023, address of the last instruction; retiring it ends the program.
MEM_TIMEOUT, 16, maximum MEM-state cycles without MemAck before Error.

Ports:
Clk  in  1  clock, rising edge.
Reset_n  in  1  asynchronous active-low reset.
Start  in  1  begin program at START_ADDR; ignored while Busy.
Instr  in  9  instruction memory read data at PC (combinational).
RegWriteDec  in  1  decoder RegWrite.
MemWriteDec  in  1  decoder MemWrite.
LoadDec  in  1  decoder Load.
BranchDec  in  1  decoder branch (beqr).
Zero  in  1  ALU equality flag for beqr.
BranchTarget  in  PC_W  absolute branch target from register file.
MemAck  in  1  data memory completion, one-cycle pulse.
PC  out  PC_W  current program counter.
Ir  out  9  instruction register, feeds decoder.
RegWriteEn  out  1  qualified register-file write enable.
MemWriteEn  out  1  data memory write request, held until ack.
MemReadEn  out  1  data memory read request, held until ack.
Busy  out  1  high in FETCH, EXEC, MEM.
Done  out  1  high in DONE.
Error  out  1  high in ERROR.

Behaviour:
- Reset (async, Reset_n=0): state IDLE, PC=0, Ir=0, timeout count=0. All enables, Busy, Done and Error are 0.
- States: IDLE, FETCH, EXEC, MEM, DONE, ERROR. All outputs are registered or decoded from state; there are no combinational paths from Start.
- IDLE/DONE/ERROR + Start=1: PC<=START_ADDR, go to FETCH. Done and Error clear on the same edge.
- FETCH, one cycle: Ir<=Instr on exit, go to EXEC. Decoder inputs are valid only in EXEC and MEM and are ignored in all other states.
- EXEC:
  - If LoadDec|MemWriteDec: go to MEM with count=0. PC is held.
  - Else retire: RegWriteEn=RegWriteDec for this one cycle.
    - PC<=BranchTarget if BranchDec&Zero, else PC+1 (modulo 2^PC_W, wraps 1023->0).
    - Next state is DONE if the retiring PC==END_ADDR, else FETCH. A taken branch at END_ADDR still goes to DONE.
  - Memory check has priority over branch.
- MEM:
  - MemReadEn=LoadDec and MemWriteEn=MemWriteDec, held every cycle until ack.
  - On MemAck: drop both enables the next cycle. RegWriteEn=LoadDec in the ack cycle. PC<=PC+1. Next state DONE/FETCH by the same END_ADDR rule.
  - Without MemAck: count increments. When count==MEM_TIMEOUT-1 and no ack, go to ERROR with PC held.
  - MemAck in the same cycle as the timeout limit: ack wins, normal retire.
- Latency: non-memory instruction = 2 cycles (FETCH+EXEC). Memory instruction = 2 + k cycles, where k = cycles in MEM including the ack cycle (min 1).
- MemAck outside MEM is ignored.
- ERROR and DONE are sticky until Start or reset.
- Reset asserted mid-instruction aborts immediately. No write enable may be high after Reset_n falls.

Decomposition:
- Package cpu_ctrl_pkg: seq_state_t enum (IDLE, FETCH, EXEC, MEM, DONE, ERROR), INSTR_W=9, default PC_W.
- One sub-module: mem_timeout_ctr (clear, enable, limit-reached output, width $clog2(MEM_TIMEOUT)). FSM and PC stay in instr_sequencer.

Test Plan:
1. Reset then Start with START_ADDR=0, three non-memory RegWrite instructions, END_ADDR=2 -> PC 0,1,2; RegWriteEn pulses once per EXEC (cycles 2,4,6 after Start); Done=1 after cycle 6; Busy=0.
2. beqr at PC=5 with Zero=1, BranchTarget=40 -> PC=40 next FETCH, RegWriteEn=0. Repeat with Zero=0 -> PC=6.
3. Load at PC=3, MemAck delayed 4 cycles -> MemReadEn high 4 cycles; RegWriteEn=1 only in the ack cycle; PC=4; total 6 cycles.
4. Store, MEM_TIMEOUT=16, no MemAck -> Error=1 after 16 MEM cycles, MemWriteEn=0, PC unchanged. Then Start -> Error=0, PC=START_ADDR.
5. MemAck exactly on the 16th MEM cycle -> normal retire, Error stays 0. Start pulsed while Busy -> ignored, PC unaffected.
6. PC=1023 non-branch with END_ADDR=1023 -> PC wraps to 0 and Done=1. Reset_n dropped mid-MEM -> all enables 0 asynchronously, state IDLE.
